// File: rtl/lsu_align_unit.sv
// lsu_align_unit: rebases and splits byte/half/word loads and stores onto a 4-lane sync-read word RAM
module lsu_align_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_2000,
  parameter int DEPTH_WORDS = 4096,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [2:0]    req_fn3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic          resp_fault,
  output logic [31:0]   resp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, BEAT0 = 3'd1, BEAT1 = 3'd2, WAIT = 3'd3, RESP = 3'd4;
  logic [2:0] state;
  logic wr_q, split_q, fault_q;
  logic [2:0] fn3_q;
  logic [1:0] b_q;
  logic [AW-1:0] w_q;
  logic [31:0] wdata_q, lo, hi;
  logic [31:0] off;
  logic [2:0] size;
  logic split_in, fault_in, act, beat1;
  logic [3:0] mask;
  logic [7:0] en8;
  logic [63:0] d64;
  logic [31:0] sh, ext;
  always_comb begin
    off = req_addr - BASE_ADDR;
    size = req_fn3[1:0] == 2'b00 ? 3'd1 : req_fn3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    split_in = {1'b0, off[1:0]} + size > 3'd4;
    fault_in = req_fn3 == 3'b011 || req_fn3[2:1] == 2'b11 || (req_wr && req_fn3[2]) ||
               (|off[31:AW+2]) || (split_in && off[AW+1:2] == AW'(DEPTH_WORDS - 1));
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wr_q <= 1'b0;
      split_q <= 1'b0;
      fault_q <= 1'b0;
      fn3_q <= 3'b0;
      b_q <= 2'b0;
      w_q <= '0;
      wdata_q <= 32'h0;
      lo <= 32'h0;
      hi <= 32'h0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            state <= fault_in ? RESP : BEAT0;
            wr_q <= req_wr;
            fn3_q <= req_fn3;
            wdata_q <= req_wdata;
            b_q <= off[1:0];
            w_q <= off[AW+1:2];
            split_q <= split_in;
            fault_q <= fault_in;
            lo <= 32'h0;
            hi <= 32'h0;
          end
        BEAT0: state <= split_q ? BEAT1 : wr_q ? RESP : WAIT;
        BEAT1: begin
          state <= wr_q ? RESP : WAIT;
          if (!wr_q) lo <= mem_rdata;
        end
        WAIT: begin
          state <= RESP;
          if (split_q) hi <= mem_rdata;
          else lo <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
  always_comb begin
    act = !rst && (state == BEAT0 || state == BEAT1);
    beat1 = state == BEAT1;
    mask = fn3_q[1:0] == 2'b00 ? 4'h1 : fn3_q[1:0] == 2'b01 ? 4'h3 : 4'hf;
    en8 = {4'h0, mask} << b_q;
    d64 = {32'h0, wdata_q} << {b_q, 3'b000};
    mem_en = act;
    mem_we = act && wr_q;
    mem_be = !act ? 4'h0 : !wr_q ? 4'hf : beat1 ? en8[7:4] : en8[3:0];
    mem_addr = !act ? '0 : beat1 ? w_q + AW'(1) : w_q;
    mem_wdata = !(act && wr_q) ? 32'h0 : beat1 ? d64[63:32] : d64[31:0];
    sh = 32'({hi, lo} >> {b_q, 3'b000});
    ext = fn3_q[1:0] == 2'b00 ? {{24{~fn3_q[2] & sh[7]}}, sh[7:0]} :
          fn3_q[1:0] == 2'b01 ? {{16{~fn3_q[2] & sh[15]}}, sh[15:0]} : sh;
    req_ready = !rst && state == IDLE;
    resp_valid = !rst && state == RESP;
    resp_fault = resp_valid && fault_q;
    resp_rdata = resp_valid && !wr_q && !fault_q ? ext : 32'h0;
  end
endmodule
